// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, state encoding and helpers for the CORDIC scheduler
package cordic_pkg;
  localparam int W        = 32;
  localparam int AMAX_DEF = 74055;
  localparam int LAT_DEF  = 18;
  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_IDLE  = 2'd3;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic signed [W-1:0] clamp_q(input logic signed [W-1:0] a, input logic signed [W-1:0] m);
    return a > m ? m : (a < -m ? -m : a);
  endfunction
endpackage

// File: rtl/cordic_hyp_sched_rr_arbiter.sv
// rr_arbiter: N-way round-robin grant with pointer update
//   clk, rst_n : clock, async active-low reset
//   i_en       : grants allowed this cycle
//   i_req      : request vector
//   o_gnt      : one-hot grant (combinational)
//   o_idx      : granted index, o_any : a grant is being made
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [N-1:0]        i_req,
  output logic [N-1:0]        o_gnt,
  output logic [id_w(N)-1:0]  o_idx,
  output logic                o_any
);
  localparam int IW = id_w(N);
  logic [IW-1:0] r_ptr, w_j;
  // Scan from the farthest offset down so the nearest requester at or above the pointer wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(r_ptr) + k) % N);
      if (i_en && i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
      end
    end
  end
  assign o_gnt = o_any ? N'(1) << o_idx : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (o_any) r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/cordic_hyp_sched.sv
// cordic_hyp_sched: round-robin scheduler sharing one CORDIC sinh/cosh pipeline between N requesters
//   clk, rst_n                       : clock, async active-low reset
//   en                               : 1 = grants allowed, 0 = stop granting and drain
//   req_vld, req_alpha               : per-requester valid and Q16.16 angle (32 bits each)
//   req_rdy                          : one-hot grant
//   cordic_alpha, cordic_vld         : registered issue into the CORDIC
//   cordic_sinh/cosh/post_vld        : CORDIC results
//   rsp_vld, rsp_sinh/cosh/clamped   : routed response, data zero when no response
//   busy                             : not IDLE or work in flight
//   align_err                        : sticky CORDIC valid vs tag pipeline disagreement
module cordic_hyp_sched
  import cordic_pkg::*;
#(
  parameter int N    = 4,
  parameter int LAT  = LAT_DEF,
  parameter int AMAX = AMAX_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req_vld,
  input  logic [W*N-1:0] req_alpha,
  output logic [N-1:0]   req_rdy,
  output logic [W-1:0]   cordic_alpha,
  output logic           cordic_vld,
  input  logic [W-1:0]   cordic_sinh,
  input  logic [W-1:0]   cordic_cosh,
  input  logic           cordic_post_vld,
  output logic [N-1:0]   rsp_vld,
  output logic [W-1:0]   rsp_sinh,
  output logic [W-1:0]   rsp_cosh,
  output logic           rsp_clamped,
  output logic           busy,
  output logic           align_err
);
  localparam int IW = id_w(N);
  localparam int CW = $clog2(LAT + 2);
  localparam logic signed [W-1:0] AMAX_Q = W'(AMAX);
  logic [1:0]                r_state, w_nstate;
  logic [CW-1:0]             r_cnt;
  logic [IW-1:0]             w_gidx, r_cid;
  logic                      w_gany, r_cvld, r_ccl, w_inflight, r_err, r_rsp_cl;
  logic signed [W-1:0]       w_req_a [N];
  logic signed [W-1:0]       w_clip, r_calpha;
  logic [LAT-1:0]            r_tv, r_tc;
  logic [LAT-1:0][IW-1:0]    r_tid;
  logic [N-1:0]              r_rsp_vld;
  logic [W-1:0]              r_rsp_s, r_rsp_c;
  rr_arbiter #(.N(N)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (r_state == S_RUN),
    .i_req (req_vld),
    .o_gnt (req_rdy),
    .o_idx (w_gidx),
    .o_any (w_gany)
  );
  always_comb
    for (int i = 0; i < N; i++) w_req_a[i] = req_alpha[W*i +: W];
  assign w_clip     = clamp_q(w_req_a[w_gidx], AMAX_Q);
  assign w_inflight = r_cvld | (|r_tv);
  // INIT waits out the unreset CORDIC valid pipe before anything may be granted.
  assign w_nstate = r_state == S_INIT  ? (r_cnt == CW'(LAT) ? (en ? S_RUN : S_IDLE) : S_INIT)
                  : r_state == S_RUN   ? (en ? S_RUN : S_DRAIN)
                  : r_state == S_DRAIN ? (en ? S_RUN : (w_inflight ? S_DRAIN : S_IDLE))
                  : (en ? S_RUN : S_IDLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_cvld    <= 1'b0;
      r_calpha  <= '0;
      r_cid     <= '0;
      r_ccl     <= 1'b0;
      r_tv      <= '0;
      r_tc      <= '0;
      r_tid     <= '0;
      r_rsp_vld <= '0;
      r_rsp_s   <= '0;
      r_rsp_c   <= '0;
      r_rsp_cl  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= r_state == S_INIT ? r_cnt + 1'b1 : r_cnt;
      r_cvld  <= w_gany;
      if (w_gany) begin
        r_calpha <= w_clip;
        r_cid    <= w_gidx;
        r_ccl    <= w_clip != w_req_a[w_gidx];
      end
      // Tag enters alongside cordic_vld so it emerges in the cycle cordic_post_vld is due.
      r_tv      <= {r_tv[LAT-2:0], r_cvld};
      r_tc      <= {r_tc[LAT-2:0], r_ccl};
      r_tid     <= {r_tid[LAT-2:0], r_cid};
      r_rsp_vld <= r_tv[LAT-1] ? N'(1) << r_tid[LAT-1] : '0;
      r_rsp_s   <= r_tv[LAT-1] ? cordic_sinh : '0;
      r_rsp_c   <= r_tv[LAT-1] ? cordic_cosh : '0;
      r_rsp_cl  <= r_tv[LAT-1] & r_tc[LAT-1];
      if (r_state != S_INIT && r_tv[LAT-1] != cordic_post_vld) r_err <= 1'b1;
    end
  assign cordic_alpha = r_calpha;
  assign cordic_vld   = r_cvld;
  assign rsp_vld      = r_rsp_vld;
  assign rsp_sinh     = r_rsp_s;
  assign rsp_cosh     = r_rsp_c;
  assign rsp_clamped  = r_rsp_cl;
  assign busy         = (r_state != S_IDLE) | w_inflight;
  assign align_err    = r_err;
endmodule
